// File: rtl/pulse_stretch_mc.sv
// Multi-channel pulse stretcher: each channel runs an IDLE/ACTIVE/HOLDOFF FSM with a
// down-counter, fed by a two-flop edge detector on its (polarity-normalised) input.
module pulse_stretch_mc #(
  parameter int    CH     = 4,
  parameter int    CNT_W  = 8,
  parameter string PHASE  = "POSITIVE",
  parameter string MODE   = "EDGE",
  parameter bit    RETRIG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] len,
  input  logic [CNT_W-1:0] gap,
  input  logic [CH-1:0]    d,
  input  logic             miss_clr,
  output logic [CH-1:0]    q,
  output logic [CH-1:0]    busy,
  output logic [CH-1:0]    miss,
  output logic [2*CH-1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam bit NEG = (PHASE == "NEGATIVE");
  localparam bit LVL = (MODE == "LEVEL");
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CH-1:0]    a;
  logic [CH-1:0]    act;
  logic [CNT_W-1:0] len_ld;

  assign a      = NEG ? ~d : d;
  assign len_ld = (len == '0) ? ONE : len;
  assign q      = NEG ? ~act : act;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             s1;
    logic             s2;
    logic             miss_r;
    logic             trig;
    logic             reload;
    logic             drop;

    assign trig   = s1 & ~s2;
    // LEVEL extends while the input is held; EDGE only reloads on a fresh edge.
    assign reload = LVL ? s1 : (RETRIG & trig);
    assign drop   = en & trig &
                    ((st == HOLDOFF) | ((st == ACTIVE) & ~LVL & ~RETRIG));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st     <= IDLE;
        cnt    <= '0;
        s1     <= 1'b0;
        s2     <= 1'b0;
        miss_r <= 1'b0;
      end else begin
        s1 <= a[i];
        s2 <= s1;
        if (drop) begin
          miss_r <= 1'b1;
        end else if (miss_clr) begin
          miss_r <= 1'b0;
        end
        if (!en) begin
          st  <= IDLE;
          cnt <= '0;
        end else begin
          case (st)
            IDLE: begin
              if (trig) begin
                st  <= ACTIVE;
                cnt <= len_ld;
              end
            end
            ACTIVE: begin
              if (reload) begin
                cnt <= len_ld;
              end else if (cnt == ONE) begin
                if (gap != '0) begin
                  st  <= HOLDOFF;
                  cnt <= gap;
                end else begin
                  st  <= IDLE;
                  cnt <= '0;
                end
              end else begin
                cnt <= cnt - ONE;
              end
            end
            HOLDOFF: begin
              if (cnt == ONE) begin
                st  <= IDLE;
                cnt <= '0;
              end else begin
                cnt <= cnt - ONE;
              end
            end
            default: begin
              st  <= IDLE;
              cnt <= '0;
            end
          endcase
        end
      end
    end

    assign act[i]             = (st == ACTIVE);
    assign busy[i]            = (st != IDLE);
    assign miss[i]            = miss_r;
    assign state_dbg[2*i +: 2] = st;
  end

endmodule

// File: tb/tb_pulse_stretch_mc.sv
// Bench for pulse_stretch_mc: four instances cover EDGE/RETRIG, EDGE/no-retrig,
// LEVEL and NEGATIVE polarity; waveforms are recorded per cycle and compared to masks.
module tb_pulse_stretch_mc;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] len;
  logic [7:0] gap;
  logic [3:0] d;
  logic [3:0] d_n;
  logic       miss_clr;

  logic [3:0] q_e, busy_e, miss_e;
  logic [3:0] q_n, busy_n, miss_n;
  logic [3:0] q_l, busy_l, miss_l;
  logic [3:0] q_g, busy_g, miss_g;
  logic [7:0] st_e, st_n, st_l, st_g;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  assign d_n = ~d;

  pulse_stretch_mc #(.CH(4), .CNT_W(8), .PHASE("POSITIVE"), .MODE("EDGE"), .RETRIG(1'b1)) u_e (
    .clk(clk), .rst_n(rst_n), .en(en), .len(len), .gap(gap), .d(d), .miss_clr(miss_clr),
    .q(q_e), .busy(busy_e), .miss(miss_e), .state_dbg(st_e));

  pulse_stretch_mc #(.CH(4), .CNT_W(8), .PHASE("POSITIVE"), .MODE("EDGE"), .RETRIG(1'b0)) u_n (
    .clk(clk), .rst_n(rst_n), .en(en), .len(len), .gap(gap), .d(d), .miss_clr(miss_clr),
    .q(q_n), .busy(busy_n), .miss(miss_n), .state_dbg(st_n));

  pulse_stretch_mc #(.CH(4), .CNT_W(8), .PHASE("POSITIVE"), .MODE("LEVEL"), .RETRIG(1'b1)) u_l (
    .clk(clk), .rst_n(rst_n), .en(en), .len(len), .gap(gap), .d(d), .miss_clr(miss_clr),
    .q(q_l), .busy(busy_l), .miss(miss_l), .state_dbg(st_l));

  pulse_stretch_mc #(.CH(4), .CNT_W(8), .PHASE("NEGATIVE"), .MODE("EDGE"), .RETRIG(1'b1)) u_g (
    .clk(clk), .rst_n(rst_n), .en(en), .len(len), .gap(gap), .d(d_n), .miss_clr(miss_clr),
    .q(q_g), .busy(busy_g), .miss(miss_g), .state_dbg(st_g));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         dut;
    int         ch;
    logic [7:0] len;
    logic [7:0] gap;
    logic [19:0] d_pat;
    logic [19:0] exp_q;
    logic [19:0] exp_busy;
    logic       exp_miss;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [3:0] pick_q(int dn);
    case (dn)
      0:       return q_e;
      1:       return q_n;
      default: return q_l;
    endcase
  endfunction

  function automatic logic [3:0] pick_busy(int dn);
    case (dn)
      0:       return busy_e;
      1:       return busy_n;
      default: return busy_l;
    endcase
  endfunction

  function automatic logic [3:0] pick_miss(int dn);
    case (dn)
      0:       return miss_e;
      1:       return miss_n;
      default: return miss_l;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic settle(input logic [7:0] l, input logic [7:0] g);
    len      = l;
    gap      = g;
    d        = 4'h0;
    miss_clr = 1'b1;
    step();
    miss_clr = 1'b0;
    step();
    step();
  endtask

  task automatic run_vec(input int idx);
    vec_t       v;
    logic [19:0] wq;
    logic [19:0] wb;
    logic [3:0]  oth;
    logic [3:0]  m;
    v   = vecs[idx];
    wq  = '0;
    wb  = '0;
    oth = '0;
    m   = 4'b0001 << v.ch;
    settle(v.len, v.gap);
    for (int k = 0; k < 20; k++) begin
      wq[k] = pick_q(v.dut)[v.ch];
      wb[k] = pick_busy(v.dut)[v.ch];
      oth   = oth | ((pick_q(v.dut) | pick_busy(v.dut)) & ~m);
      d     = v.d_pat[k] ? m : 4'h0;
      step();
    end
    d = 4'h0;
    exp_q.push_back(32'(v.exp_q));
    exp_q.push_back(32'(v.exp_busy));
    exp_q.push_back(32'(v.exp_miss));
    exp_q.push_back(32'h0);
    chk({v.name, "_q"},     32'(wq),                          exp_q.pop_front());
    chk({v.name, "_busy"},  32'(wb),                          exp_q.pop_front());
    chk({v.name, "_miss"},  32'(pick_miss(v.dut)[v.ch]),      exp_q.pop_front());
    chk({v.name, "_other"}, 32'(oth),                         exp_q.pop_front());
  endtask

  initial begin
    logic [9:0] wlow;
    logic       mixed;
    checks   = 0;
    failures = 0;

    // name, dut, ch, len, gap, d_pat, exp_q, exp_busy, exp_miss
    vecs[0]  = '{"edge_len4",     0, 0, 8'd4, 8'd0, 20'h00001, 20'h0003C, 20'h0003C, 1'b0};
    vecs[1]  = '{"retrig",        0, 0, 8'd4, 8'd0, 20'h00005, 20'h000FC, 20'h000FC, 1'b0};
    vecs[2]  = '{"no_retrig",     1, 0, 8'd4, 8'd0, 20'h00005, 20'h0003C, 20'h0003C, 1'b1};
    vecs[3]  = '{"gap3",          0, 0, 8'd2, 8'd3, 20'h00001, 20'h0000C, 20'h0007C, 1'b0};
    vecs[4]  = '{"gap_drop_last", 0, 0, 8'd2, 8'd3, 20'h00021, 20'h0000C, 20'h0007C, 1'b1};
    vecs[5]  = '{"gap_after",     0, 0, 8'd2, 8'd3, 20'h00041, 20'h0030C, 20'h01F7C, 1'b0};
    vecs[6]  = '{"gap_drop_mid",  1, 0, 8'd2, 8'd3, 20'h00011, 20'h0000C, 20'h0007C, 1'b1};
    vecs[7]  = '{"len0",          0, 0, 8'd0, 8'd0, 20'h00001, 20'h00004, 20'h00004, 1'b0};
    vecs[8]  = '{"level_hold",    2, 1, 8'd3, 8'd0, 20'h003FF, 20'h03FFC, 20'h03FFC, 1'b0};
    vecs[9]  = '{"level_strobe",  2, 2, 8'd4, 8'd0, 20'h00001, 20'h0003C, 20'h0003C, 1'b0};
    vecs[10] = '{"level_norefire",2, 0, 8'd2, 8'd2, 20'hFFFF1, 20'h0000C, 20'h0003C, 1'b1};
    vecs[11] = '{"ch3_edge",      0, 3, 8'd4, 8'd0, 20'h00001, 20'h0003C, 20'h0003C, 1'b0};

    rst_n    = 1'b0;
    en       = 1'b1;
    len      = 8'd4;
    gap      = 8'd0;
    d        = 4'h0;
    miss_clr = 1'b0;
    repeat (3) step();
    chk("reset_q",     32'(q_e),    32'h0);
    chk("reset_busy",  32'(busy_e), 32'h0);
    chk("reset_miss",  32'(miss_n), 32'h0);
    chk("reset_q_neg", 32'(q_g),    32'hF);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) run_vec(i);

    // NEGATIVE polarity: low strobe on every channel, all outputs low in lockstep
    settle(8'd5, 8'd0);
    wlow  = '0;
    mixed = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wlow[k] = (q_g == 4'h0);
      if (q_g != 4'h0 && q_g != 4'hF) mixed = 1'b1;
      d = (k == 0) ? 4'hF : 4'h0;
      step();
    end
    chk("neg_lockstep_low", 32'(wlow),  32'h07C);
    chk("neg_lockstep_mix", 32'(mixed), 32'h0);

    // Set wins over miss_clr in the same cycle, flag is sticky, then miss_clr clears it
    settle(8'd4, 8'd0);
    d = 4'h1; step();
    d = 4'h0; step();
    d = 4'h1; step();
    d = 4'h0; miss_clr = 1'b1; step();
    miss_clr = 1'b0;
    chk("miss_set_wins", 32'(miss_n[0]), 32'h1);
    repeat (3) step();
    chk("miss_sticky", 32'(miss_n[0]), 32'h1);
    miss_clr = 1'b1; step();
    miss_clr = 1'b0;
    chk("miss_clr", 32'(miss_n[0]), 32'h0);

    // Asynchronous reset in the middle of a pulse
    settle(8'd8, 8'd0);
    d = 4'h1; step();
    d = 4'h0; step();
    step();
    chk("pre_rst_active", 32'(q_e[0]), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q",      32'(q_e),    32'h0);
    chk("async_rst_busy",   32'(busy_e), 32'h0);
    chk("async_rst_q_neg",  32'(q_g),    32'hF);
    chk("async_rst_bsy_ng", 32'(busy_g), 32'h0);
    #2;
    rst_n = 1'b1;
    step();

    // en=0 mid-pulse, then strobes while disabled
    settle(8'd8, 8'd0);
    d = 4'h1; step();
    d = 4'h0; step();
    step();
    chk("pre_en_active", 32'(q_e[0]), 32'h1);
    en = 1'b0;
    step();
    chk("en_off_q",    32'(q_e),    32'h0);
    chk("en_off_busy", 32'(busy_e), 32'h0);
    d = 4'hF; step();
    d = 4'h0; step();
    d = 4'hF; step();
    d = 4'h0;
    repeat (3) step();
    chk("en_off_no_start", 32'(q_n | busy_n | q_e), 32'h0);
    chk("en_off_no_miss",  32'(miss_n),             32'h0);
    en = 1'b1;

    // Normal operation resumes after re-enable
    settle(8'd4, 8'd0);
    d = 4'h2; step();
    d = 4'h0; step();
    chk("reenable_active", 32'(q_e), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
